// File: rtl/twos_comp_sched.sv
// Two-requester round-robin scheduler around a bit-serial two's-complement negator.
// Latency: grant one cycle after accept, done WIDTH cycles after the grant, one op per WIDTH+2 cycles.
// Backpressure: requesters hold req until their grant; requests are only sampled while idle.
module twos_comp_sched #(
    parameter int WIDTH = 12
) (
    input  logic             t_clk,
    input  logic             t_rst_n,
    input  logic             req_a,
    input  logic [WIDTH-1:0] opnd_a,
    input  logic             req_b,
    input  logic [WIDTH-1:0] opnd_b,
    output logic             gnt_a,
    output logic             gnt_b,
    output logic             done_a,
    output logic             done_b,
    output logic [WIDTH-1:0] result,
    output logic             ovf,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [1:0]       rst_sync;
    logic             rst_int_n;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    cnt;
    logic             f;
    logic             last_b;
    logic             pick_b;
    logic             out_bit;

    // Assert asynchronously, release two edges after t_rst_n rises.
    always_ff @(posedge t_clk or negedge t_rst_n) begin
        if (!t_rst_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync[1];

    always_comb begin
        pick_b  = (req_a && req_b) ? !last_b : req_b;
        out_bit = sr[0] ^ f;
    end

    // last_b doubles as the owner of the operation in flight.
    always_ff @(posedge t_clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state  <= IDLE;
            busy   <= 1'b0;
            gnt_a  <= 1'b0;
            gnt_b  <= 1'b0;
            done_a <= 1'b0;
            done_b <= 1'b0;
            result <= '0;
            ovf    <= 1'b0;
            sr     <= '0;
            acc    <= '0;
            cnt    <= '0;
            f      <= 1'b0;
            last_b <= 1'b1;
        end else begin
            gnt_a  <= 1'b0;
            gnt_b  <= 1'b0;
            done_a <= 1'b0;
            done_b <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_a || req_b) begin
                        sr     <= pick_b ? opnd_b : opnd_a;
                        last_b <= pick_b;
                        gnt_a  <= !pick_b;
                        gnt_b  <= pick_b;
                        f      <= 1'b0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    acc <= {out_bit, acc[WIDTH-1:1]};
                    sr  <= sr >> 1;
                    f   <= f | sr[0];
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        result <= {out_bit, acc[WIDTH-1:1]};
                        // Most-negative: no ones below the MSB, MSB set.
                        ovf    <= !f && sr[0];
                        done_a <= !last_b;
                        done_b <= last_b;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_twos_comp_sched.sv
// Bench for twos_comp_sched: transaction-level model checked every cycle, plus directed literal cases.
module tb_twos_comp_sched;
    localparam int WIDTH = 12;

    logic             t_clk = 1'b0;
    logic             t_rst_n = 1'b0;
    logic             req_a = 1'b0;
    logic             req_b = 1'b0;
    logic [WIDTH-1:0] opnd_a = '0;
    logic [WIDTH-1:0] opnd_b = '0;
    logic             gnt_a, gnt_b, done_a, done_b, ovf, busy;
    logic [WIDTH-1:0] result;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    twos_comp_sched #(.WIDTH(WIDTH)) dut (
        .t_clk(t_clk), .t_rst_n(t_rst_n),
        .req_a(req_a), .opnd_a(opnd_a), .req_b(req_b), .opnd_b(opnd_b),
        .gnt_a(gnt_a), .gnt_b(gnt_b), .done_a(done_a), .done_b(done_b),
        .result(result), .ovf(ovf), .busy(busy)
    );

    always #5 t_clk = ~t_clk;

    initial forever begin
        @(posedge t_clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: one operation occupies edges E0..E(WIDTH+1) measured from its accept edge.
    bit               m_active = 1'b0;
    int               m_age = 0;
    bit               m_win = 1'b0;
    bit               m_last = 1'b1;
    logic [WIDTH-1:0] m_op = '0;
    logic [WIDTH-1:0] m_res = '0;
    bit               m_ovf = 1'b0;

    initial forever begin
        @(posedge t_clk or negedge t_rst_n);
        if (!t_rst_n) begin
            m_active = 1'b0;
            m_age    = 0;
            m_last   = 1'b1;
            m_res    = '0;
            m_ovf    = 1'b0;
        end else if (m_active) begin
            m_age++;
            if (m_age == WIDTH) begin
                m_res = -m_op;
                m_ovf = (m_op == {1'b1, {(WIDTH-1){1'b0}}});
            end
            if (m_age == WIDTH + 1) m_active = 1'b0;
        end else if (req_a || req_b) begin
            m_win    = (req_a && req_b) ? !m_last : req_b;
            m_last   = m_win;
            m_op     = m_win ? opnd_b : opnd_a;
            m_active = 1'b1;
            m_age    = 0;
        end
    end

    initial forever begin
        @(negedge t_clk);
        chk("outputs", {gnt_a, gnt_b, done_a, done_b, busy, ovf, result},
            {m_active && m_age == 0 && !m_win, m_active && m_age == 0 && m_win,
             m_active && m_age == WIDTH && !m_win, m_active && m_age == WIDTH && m_win,
             m_active, m_ovf, m_res});
        chk("exclusive", {gnt_a & gnt_b, done_a & done_b}, 0);
    end

    task automatic apply_reset();
        @(posedge t_clk);
        #1;
        t_rst_n = 1'b0;
        req_a = 1'b0;
        req_b = 1'b0;
        repeat (2) @(negedge t_clk);
        chk("reset_outputs", {gnt_a, gnt_b, done_a, done_b, busy, ovf, result}, 0);
        @(posedge t_clk);
        #1;
        t_rst_n = 1'b1;
        repeat (3) @(posedge t_clk);
    endtask

    task automatic wait_gnt(output bit ok, output bit who);
        ok = 1'b0;
        who = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge t_clk);
            if (gnt_a || gnt_b) begin
                ok = 1'b1;
                who = gnt_b;
            end
        end
        chk("grant_seen", ok, 1);
    endtask

    task automatic wait_done(output bit ok, output logic [WIDTH-1:0] res);
        ok = 1'b0;
        res = '0;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge t_clk);
            if (done_a || done_b) begin
                ok = 1'b1;
                res = result;
            end
        end
        chk("done_seen", ok, 1);
    endtask

    // Single request; optionally alter the operand after edge chg_at of the operation.
    task automatic op(input bit b, input logic [WIDTH-1:0] val, input logic [WIDTH-1:0] exp_res,
                      input bit exp_ovf, input int chg_at, input logic [WIDTH-1:0] chg_val);
        bit ok, who, seen;
        @(posedge t_clk);
        #1;
        if (b) begin req_b = 1'b1; opnd_b = val; end
        else   begin req_a = 1'b1; opnd_a = val; end
        wait_gnt(ok, who);
        if (!ok) begin
            req_a = 1'b0;
            req_b = 1'b0;
            return;
        end
        chk("grant_who", who, b);
        seen = 1'b0;
        for (int e = 1; e <= WIDTH + 4 && !seen; e++) begin
            @(posedge t_clk);
            #1;
            if (e == 1) begin req_a = 1'b0; req_b = 1'b0; end
            if (e == chg_at) begin
                if (b) opnd_b = chg_val;
                else   opnd_a = chg_val;
            end
            @(negedge t_clk);
            if (done_a || done_b) begin
                seen = 1'b1;
                chk("done_edge", e, WIDTH);
                chk("done_who", {done_a, done_b}, b ? 2'b01 : 2'b10);
                chk("result", result, exp_res);
                chk("ovf", ovf, exp_ovf);
            end
        end
        chk("done_seen", seen, 1);
        if (seen) begin
            @(negedge t_clk);
            chk("busy_after_done", busy, 0);
            chk("result_hold", result, exp_res);
        end
    endtask

    function automatic logic [WIDTH-1:0] rand_opnd();
        logic [WIDTH-1:0] v;
        case ($urandom_range(0, 7))
            0: v = '0;
            1: v = {1'b1, {(WIDTH-1){1'b0}}};
            2: v = '1;
            3: v = {{(WIDTH-1){1'b0}}, 1'b1};
            default: v = WIDTH'($urandom);
        endcase
        return v;
    endfunction

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        bit ok, who;
        bit who_q[3];
        int at_q[2];
        logic [WIDTH-1:0] res_q[2];
        logic [WIDTH-1:0] r;
        int hold;

        apply_reset();

        op(1'b0, 12'h001, 12'hFFF, 1'b0, 0, '0);
        op(1'b1, 12'h800, 12'h800, 1'b1, 0, '0);
        op(1'b1, 12'h000, 12'h000, 1'b0, 0, '0);

        // Simultaneous requests right after reset: A first, then B.
        apply_reset();
        @(posedge t_clk);
        #1;
        req_a = 1'b1; opnd_a = 12'h005;
        req_b = 1'b1; opnd_b = 12'h0F0;
        for (int g = 0; g < 2; g++) begin
            wait_gnt(ok, who);
            who_q[g] = who;
            at_q[g] = cyc;
            @(posedge t_clk);
            #1;
            if (who) req_b = 1'b0;
            else     req_a = 1'b0;
            wait_done(ok, r);
            res_q[g] = r;
        end
        chk("tie_first_is_a", who_q[0], 0);
        chk("tie_second_is_b", who_q[1], 1);
        chk("tie_result_a", res_q[0], 12'hFFB);
        chk("tie_result_b", res_q[1], 12'hF10);
        chk("accept_spacing", at_q[1] - at_q[0], WIDTH + 2);
        req_a = 1'b0;
        req_b = 1'b0;
        repeat (4) @(posedge t_clk);

        // Three back-to-back ties with both requests held throughout.
        #1;
        req_a = 1'b1; opnd_a = 12'h3C3;
        req_b = 1'b1; opnd_b = 12'h7FF;
        for (int g = 0; g < 3; g++) begin
            wait_gnt(ok, who);
            who_q[g] = who;
        end
        @(posedge t_clk);
        #1;
        req_a = 1'b0;
        req_b = 1'b0;
        chk("rr_order_0", who_q[0], 0);
        chk("rr_order_1", who_q[1], 1);
        chk("rr_order_2", who_q[2], 0);
        wait_done(ok, r);
        chk("rr_last_result", r, 12'hC3D);
        repeat (3) @(posedge t_clk);

        // Reset in the middle of an operation.
        #1;
        req_a = 1'b1; opnd_a = 12'h123;
        wait_gnt(ok, who);
        for (int e = 1; e <= 6; e++) begin
            @(posedge t_clk);
            #1;
            if (e == 1) req_a = 1'b0;
            if (e == 6) t_rst_n = 1'b0;
            @(negedge t_clk);
            chk("no_done_before_abort", {done_a, done_b}, 0);
        end
        @(negedge t_clk);
        chk("abort_outputs", {gnt_a, gnt_b, done_a, done_b, busy, ovf, result}, 0);
        @(posedge t_clk);
        #1;
        t_rst_n = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(negedge t_clk);
            chk("no_done_after_abort", {done_a, done_b}, 0);
        end
        op(1'b0, 12'h123, 12'hEDD, 1'b0, 0, '0);

        // Operand changes mid-operation are ignored.
        op(1'b0, 12'h00F, 12'hFF1, 1'b0, 3, 12'h0FF);

        // Randomized traffic, including dropped requests, operand churn and resets.
        hold = 0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge t_clk);
            #1;
            if (!t_rst_n) begin
                t_rst_n = 1'b1;
                hold = 3;
            end else if (hold > 0) begin
                hold--;
            end else if ($urandom_range(0, 299) == 0) begin
                t_rst_n = 1'b0;
                req_a = 1'b0;
                req_b = 1'b0;
            end else begin
                if (req_a) begin
                    if (gnt_a) req_a = 1'($urandom_range(0, 1));
                    else if ($urandom_range(0, 19) == 0) req_a = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    req_a = 1'b1;
                    opnd_a = rand_opnd();
                end
                if (req_b) begin
                    if (gnt_b) req_b = 1'($urandom_range(0, 1));
                    else if ($urandom_range(0, 19) == 0) req_b = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    req_b = 1'b1;
                    opnd_b = rand_opnd();
                end
                if (busy && $urandom_range(0, 3) == 0) opnd_a = rand_opnd();
                if (busy && $urandom_range(0, 3) == 0) opnd_b = rand_opnd();
            end
        end
        req_a = 1'b0;
        req_b = 1'b0;
        t_rst_n = 1'b1;
        repeat (20) @(posedge t_clk);
        @(negedge t_clk);
        chk("final_idle", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
